// File: rtl/addr_trans_rsp_queue.sv
// addr_trans_rsp_queue: registers an accepted translation request for one cycle, folds in the MMU response, and queues the result for the cache.
// Ports: clk, a_rst_n (async active-low); flush_i; req_* request handshake and fields; mmu_* response one cycle after accept;
//        out_valid_o/out_ready_i downstream handshake with the head entry on out_*.
// Build option: define ADDR_TRANS_ALE_CHECK_EN to flag misaligned load/store (ALE, ecode 0x09) ahead of MMU exceptions.
module addr_trans_rsp_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             a_rst_n,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_vaddr_i,
  input  logic [1:0]       req_mem_type_i,
  input  logic [1:0]       req_size_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic [31:0]      mmu_paddr_i,
  input  logic             mmu_uncache_i,
  input  logic [5:0]       mmu_exc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_paddr_o,
  output logic [31:0]      out_vaddr_o,
  output logic             out_uncache_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_exc_o,
  output logic [5:0]       out_ecode_o,
  output logic             out_esubcode_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_vaddr_q, s1_vaddr_d;
  logic [1:0]       s1_mem_type_q, s1_mem_type_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [31:0]      mem_paddr_q [DEPTH];
  logic [31:0]      mem_vaddr_q [DEPTH];
  logic             mem_uncache_q [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];
  logic [5:0]       mem_ecode_q [DEPTH];
  logic             accept, push, pop, ale, has_entry;
  logic [5:0]       ecode;
`ifdef ADDR_TRANS_ALE_CHECK_EN
  logic [1:0] s1_size_q, s1_size_d;
  assign ale = (s1_mem_type_q == 2'd1 || s1_mem_type_q == 2'd2) &&
               ((s1_size_q == 2'd1 && s1_vaddr_q[0]) || (s1_size_q == 2'd2 && s1_vaddr_q[1:0] != 2'b00));
`else
  logic unused_inputs;
  assign unused_inputs = ^{req_size_i, s1_mem_type_q};
  assign ale = 1'b0;
`endif
  // Ready is taken from registers only: the S1 entry already owns a slot, and a same-cycle pop earns no credit.
  assign req_ready_o = !flush_i && ((count_q + CW'(s1_valid_q)) < CW'(DEPTH));
  assign out_valid_o = (count_q != '0) && !flush_i;
  assign accept = req_valid_i && req_ready_o;
  assign push = s1_valid_q && !flush_i;
  assign pop = out_valid_o && out_ready_i;
  assign has_entry = count_q != '0;
  // An excepting entry still carries the raw MMU paddr; the stored ecode alone encodes whether it excepted.
  assign ecode = ale              ? 6'h09 :
                 mmu_exc_i[5]     ? 6'h3F :
                 mmu_exc_i[4]     ? 6'h03 :
                 mmu_exc_i[3]     ? 6'h01 :
                 mmu_exc_i[2]     ? 6'h02 :
                 mmu_exc_i[1]     ? 6'h07 :
                 mmu_exc_i[0]     ? 6'h04 : 6'h00;
  always_comb begin
    s1_valid_d    = accept;
    s1_vaddr_d    = accept ? req_vaddr_i : s1_vaddr_q;
    s1_mem_type_d = accept ? req_mem_type_i : s1_mem_type_q;
    s1_tag_d      = accept ? req_tag_i : s1_tag_q;
`ifdef ADDR_TRANS_ALE_CHECK_EN
    s1_size_d     = accept ? req_size_i : s1_size_q;
`endif
    wr_ptr_d      = flush_i ? '0 : push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d      = flush_i ? '0 : pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d       = flush_i ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_vaddr_q    <= '0;
      s1_mem_type_q <= '0;
      s1_tag_q      <= '0;
`ifdef ADDR_TRANS_ALE_CHECK_EN
      s1_size_q     <= '0;
`endif
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_vaddr_q    <= s1_vaddr_d;
      s1_mem_type_q <= s1_mem_type_d;
      s1_tag_q      <= s1_tag_d;
`ifdef ADDR_TRANS_ALE_CHECK_EN
      s1_size_q     <= s1_size_d;
`endif
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_paddr_q[wr_ptr_q]   <= mmu_paddr_i;
      mem_vaddr_q[wr_ptr_q]   <= s1_vaddr_q;
      mem_uncache_q[wr_ptr_q] <= mmu_uncache_i;
      mem_tag_q[wr_ptr_q]     <= s1_tag_q;
      mem_ecode_q[wr_ptr_q]   <= ecode;
    end
  end
  // Data storage is not reset, so the head is masked to zero while the queue is empty.
  assign out_paddr_o    = has_entry ? mem_paddr_q[rd_ptr_q] : '0;
  assign out_vaddr_o    = has_entry ? mem_vaddr_q[rd_ptr_q] : '0;
  assign out_uncache_o  = has_entry && mem_uncache_q[rd_ptr_q];
  assign out_tag_o      = has_entry ? mem_tag_q[rd_ptr_q] : '0;
  assign out_ecode_o    = has_entry ? mem_ecode_q[rd_ptr_q] : '0;
  assign out_exc_o      = has_entry && (mem_ecode_q[rd_ptr_q] != 6'h00);
  assign out_esubcode_o = 1'b0;
endmodule

// File: tb/tb_addr_trans_rsp_queue.sv
// tb_addr_trans_rsp_queue: directed scoreboard bench for addr_trans_rsp_queue.
module tb_addr_trans_rsp_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
`ifdef ADDR_TRANS_ALE_CHECK_EN
  localparam logic [5:0] EC_W_TLBR = 6'h09;
  localparam logic [5:0] EC_H_MIS  = 6'h09;
`else
  localparam logic [5:0] EC_W_TLBR = 6'h3F;
  localparam logic [5:0] EC_H_MIS  = 6'h00;
`endif
  typedef struct {
    logic [31:0]      vaddr;
    logic [1:0]       mt;
    logic [1:0]       sz;
    logic [TAG_W-1:0] tag;
    logic [31:0]      paddr;
    logic             unc;
    logic [5:0]       exc;
    logic [5:0]       ecode;
  } vec_t;
  logic clk, a_rst_n, flush_i, req_valid_i, req_ready_o;
  logic [31:0] req_vaddr_i;
  logic [1:0] req_mem_type_i, req_size_i;
  logic [TAG_W-1:0] req_tag_i;
  logic [31:0] mmu_paddr_i;
  logic mmu_uncache_i;
  logic [5:0] mmu_exc_i;
  logic out_valid_o, out_ready_i;
  logic [31:0] out_paddr_o, out_vaddr_o;
  logic out_uncache_o;
  logic [TAG_W-1:0] out_tag_o;
  logic out_exc_o;
  logic [5:0] out_ecode_o;
  logic out_esubcode_o;
  int n_chk, n_fail, n_acc, n_pop, idx;
  logic acc, ov_s, rr_s, pend_v;
  vec_t pend_r, z;
  vec_t vt[11];
  logic [78:0] exp_q[$];
  addr_trans_rsp_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_vaddr_i(req_vaddr_i), .req_mem_type_i(req_mem_type_i), .req_size_i(req_size_i), .req_tag_i(req_tag_i),
    .mmu_paddr_i(mmu_paddr_i), .mmu_uncache_i(mmu_uncache_i), .mmu_exc_i(mmu_exc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_paddr_o(out_paddr_o), .out_vaddr_o(out_vaddr_o), .out_uncache_o(out_uncache_o),
    .out_tag_o(out_tag_o), .out_exc_o(out_exc_o), .out_ecode_o(out_ecode_o), .out_esubcode_o(out_esubcode_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [78:0] exp_of(input vec_t v);
    return {v.paddr, v.vaddr, v.unc, v.tag, v.ecode != 6'h00, v.ecode, 1'b0};
  endfunction
  function automatic vec_t mkv(input logic [31:0] va, input logic [1:0] mt, input logic [1:0] sz, input logic [TAG_W-1:0] tg,
                               input logic [31:0] pa, input logic un, input logic [5:0] ex, input logic [5:0] ec);
    return '{vaddr: va, mt: mt, sz: sz, tag: tg, paddr: pa, unc: un, exc: ex, ecode: ec};
  endfunction
  function automatic vec_t mk(input int i);
    return mkv(32'h2000_0000 + 32'(i * 16), 2'd1, 2'd2, TAG_W'(i), 32'h8000_0000 + 32'(i * 256), i[0], 6'h00, 6'h00);
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // One clock cycle, entered just after a falling edge: drive the request plus the MMU answer for last cycle's accept.
  task automatic cyc(input logic v, input vec_t r);
    req_valid_i = v;
    req_vaddr_i = r.vaddr;
    req_mem_type_i = r.mt;
    req_size_i = r.sz;
    req_tag_i = r.tag;
    mmu_paddr_i = pend_v ? pend_r.paddr : 32'h0;
    mmu_uncache_i = pend_v && pend_r.unc;
    mmu_exc_i = pend_v ? pend_r.exc : 6'h00;
    #4;
    acc = v && req_ready_o;
    ov_s = out_valid_o;
    rr_s = req_ready_o;
    if (flush_i) exp_q.delete();
    if (acc) exp_q.push_back(exp_of(r));
    n_acc += int'(acc);
    pend_v = acc;
    pend_r = r;
    @(negedge clk);
  endtask
  task automatic lat(input string nm, input vec_t r);
    cyc(1'b1, r);
    chk({nm, " accept"}, int'(acc), 1);
    cyc(1'b0, z);
    chk({nm, " lat1"}, int'(ov_s), 0);
    cyc(1'b0, z);
    chk({nm, " lat2"}, int'(ov_s), 1);
  endtask
  task automatic drain(input string nm);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(1'b0, z);
    chk({nm, " drained"}, exp_q.size(), 0);
  endtask
  // Monitor: pops the scoreboard on every handshake, sampled 1ns before the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (out_valid_o && out_ready_i) begin
        n_chk++;
        n_pop++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL entry: got unexpected %h expected none", {out_paddr_o, out_vaddr_o, out_uncache_o, out_tag_o, out_exc_o, out_ecode_o, out_esubcode_o});
        end else begin
          logic [78:0] e, a;
          e = exp_q.pop_front();
          a = {out_paddr_o, out_vaddr_o, out_uncache_o, out_tag_o, out_exc_o, out_ecode_o, out_esubcode_o};
          if (a !== e) begin
            n_fail++;
            $display("FAIL entry: got %h expected %h", a, e);
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    n_chk = 0; n_fail = 0; n_acc = 0; n_pop = 0; idx = 0;
    z = mkv(32'h0, 2'd0, 2'd0, '0, 32'h0, 1'b0, 6'h00, 6'h00);
    pend_v = 1'b0; pend_r = z;
    vt[0]  = mkv(32'h1000_0004, 2'd1, 2'd2, 6'd3,  32'h0000_2004, 1'b0, 6'b000000, 6'h00);
    vt[1]  = mkv(32'h1000_0010, 2'd2, 2'd2, 6'd5,  32'h0000_3010, 1'b0, 6'b100100, 6'h3F);
    vt[2]  = mkv(32'h1000_0020, 2'd2, 2'd2, 6'd6,  32'h0000_3020, 1'b0, 6'b000011, 6'h07);
    vt[3]  = mkv(32'h1000_0030, 2'd0, 2'd2, 6'd7,  32'h0000_3030, 1'b0, 6'b010000, 6'h03);
    vt[4]  = mkv(32'h1000_0040, 2'd1, 2'd2, 6'd8,  32'h0000_3040, 1'b0, 6'b001100, 6'h01);
    vt[5]  = mkv(32'h1000_0050, 2'd2, 2'd0, 6'd9,  32'h0000_3050, 1'b0, 6'b000110, 6'h02);
    vt[6]  = mkv(32'h1000_0060, 2'd1, 2'd0, 6'd10, 32'h0000_3060, 1'b1, 6'b000001, 6'h04);
    vt[7]  = mkv(32'h1000_0072, 2'd1, 2'd2, 6'd11, 32'h0000_3072, 1'b0, 6'b100000, EC_W_TLBR);
    vt[8]  = mkv(32'h1000_0081, 2'd0, 2'd1, 6'd12, 32'h0000_3081, 1'b1, 6'b000000, 6'h00);
    vt[9]  = mkv(32'h1000_0091, 2'd2, 2'd1, 6'd13, 32'h0000_3091, 1'b0, 6'b000000, EC_H_MIS);
    vt[10] = mkv(32'h1000_00A4, 2'd1, 2'd2, 6'd14, 32'h0000_30A4, 1'b0, 6'b000000, 6'h00);
    a_rst_n = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    req_valid_i = 1'b0; req_vaddr_i = '0; req_mem_type_i = '0; req_size_i = '0; req_tag_i = '0;
    mmu_paddr_i = '0; mmu_uncache_i = 1'b0; mmu_exc_i = '0;
    #2;
    chk("reset out_valid", int'(out_valid_o), 0);
    @(negedge clk);
    a_rst_n = 1'b1;
    #1;
    chk("reset req_ready", int'(req_ready_o), 1);
    chk("reset out zero", int'(|{out_paddr_o, out_vaddr_o, out_uncache_o, out_tag_o, out_exc_o, out_ecode_o, out_esubcode_o}), 0);
    @(negedge clk);
    out_ready_i = 1'b1;
    for (int i = 0; i < 11; i++) lat($sformatf("vec%0d", i), vt[i]);
    drain("vectors");
    out_ready_i = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, mk(idx));
      if (acc) idx++;
    end
    chk("full accepts", n_acc, DEPTH);
    chk("full ready low", int'(rr_s), 0);
    chk("full out_valid", int'(ov_s), 1);
    out_ready_i = 1'b1;
    drain("full");
    cyc(1'b0, z);
    chk("ready returns", int'(rr_s), 1);
    out_ready_i = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, mk(idx));
      if (acc) idx++;
    end
    chk("steady fill", n_acc, DEPTH);
    out_ready_i = 1'b1;
    n_acc = 0;
    begin
      int p0;
      p0 = n_pop;
      for (int i = 0; i < 12; i++) begin
        cyc(1'b1, mk(idx));
        if (acc) idx++;
      end
      chk("steady accepts", n_acc, 11);
      chk("steady pops", n_pop - p0, 12);
    end
    drain("steady");
    out_ready_i = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, mk(idx));
      if (acc) idx++;
    end
    chk("flush prefill", n_acc, 4);
    flush_i = 1'b1;
    cyc(1'b1, mk(idx));
    chk("flush out_valid", int'(ov_s), 0);
    chk("flush ready", int'(rr_s), 0);
    flush_i = 1'b0;
    cyc(1'b0, z);
    chk("post flush out_valid", int'(ov_s), 0);
    chk("post flush ready", int'(rr_s), 1);
    out_ready_i = 1'b1;
    lat("post flush", mk(idx));
    idx++;
    drain("post flush");
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, mk(idx));
      if (acc) idx++;
    end
    a_rst_n = 1'b0;
    #1;
    chk("midreset out_valid", int'(out_valid_o), 0);
    exp_q.delete();
    pend_v = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    cyc(1'b0, z);
    chk("midreset ready", int'(rr_s), 1);
    chk("midreset empty", int'(ov_s), 0);
    out_ready_i = 1'b1;
    lat("post reset", mk(idx));
    drain("end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
